// File: rtl/incubator_pkg.sv
// ---------------------------------------------------------------------------
// incubator_pkg
// Definitions shared by the incubator controller and the chamber plant model:
// temperature width, plant state encoding, default saturation bounds,
// controller temperature thresholds and cooler rotation speed (CRS) codes.
// No ports (package).
// ---------------------------------------------------------------------------
package incubator_pkg;

  localparam int TEMP_W = 8;

  typedef enum logic [2:0] {
    PS_AMBIENT = 3'd0,
    PS_WARMUP  = 3'd1,
    PS_HEATING = 3'd2,
    PS_COOLING = 3'd3,
    PS_FAULT   = 3'd4
  } plant_state_t;

  localparam int T_MIN_DEF = 0;
  localparam int T_MAX_DEF = 80;

  // Controller decision thresholds (degrees)
  localparam logic [TEMP_W-1:0] TH_15 = 8'd15;
  localparam logic [TEMP_W-1:0] TH_25 = 8'd25;
  localparam logic [TEMP_W-1:0] TH_30 = 8'd30;
  localparam logic [TEMP_W-1:0] TH_35 = 8'd35;
  localparam logic [TEMP_W-1:0] TH_40 = 8'd40;
  localparam logic [TEMP_W-1:0] TH_45 = 8'd45;

  // Cooler rotation speed codes driven by the controller
  localparam logic [TEMP_W-1:0] CRS_OFF  = 8'd0;
  localparam logic [TEMP_W-1:0] CRS_LOW  = 8'd4;
  localparam logic [TEMP_W-1:0] CRS_MID  = 8'd6;
  localparam logic [TEMP_W-1:0] CRS_HIGH = 8'd8;

endpackage

// File: rtl/step_prescaler.sv
// ---------------------------------------------------------------------------
// step_prescaler
// Divides clk into thermal steps: count runs 0..STEP_CYCLES-1 and tick is
// high while count sits at its last value. A synchronous clear restarts the
// step so the next tick lands STEP_CYCLES edges after the clearing edge.
// Ports:
//   clk    in  clock
//   reset  in  asynchronous, active-low reset
//   clear  in  synchronous restart of the step count
//   tick   out high in the last cycle of each step
// ---------------------------------------------------------------------------
module step_prescaler #(
  parameter int STEP_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam int CW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

  logic [CW-1:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/incubator_plant.sv
// ---------------------------------------------------------------------------
// incubator_plant
// Closed-loop thermal model of the incubator chamber. Once per thermal step
// it samples the heater / cooler / crs commands and updates the chamber
// temperature T: heater warm-up lag, speed-dependent cooling, drift toward
// ambient, and saturation to [T_MIN, T_MAX].
// Ports:
//   clk         in   clock
//   reset       in   asynchronous, active-low reset
//   heater      in   heater command
//   cooler      in   cooler command
//   crs         in   cooler rotation speed
//   ambient     in   ambient temperature the chamber drifts toward
//   load        in   one-cycle strobe forcing T to load_value
//   load_value  in   temperature to force
//   T           out  chamber temperature (registered)
//   t_valid     out  one-cycle pulse when a new T is presented
//   fault       out  high while heater and cooler are both commanded
// ---------------------------------------------------------------------------
module incubator_plant
  import incubator_pkg::*;
#(
  parameter int DATA_W       = TEMP_W,
  parameter int STEP_CYCLES  = 4,
  parameter int WARMUP_STEPS = 2,
  parameter int HEAT_RATE    = 1,
  parameter int RESET_TEMP   = 25,
  parameter int T_MIN        = T_MIN_DEF,
  parameter int T_MAX        = T_MAX_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              heater,
  input  logic              cooler,
  input  logic [DATA_W-1:0] crs,
  input  logic [DATA_W-1:0] ambient,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  output logic [DATA_W-1:0] T,
  output logic              t_valid,
  output logic              fault
);

  // One extra bit gives a signed intermediate that cannot wrap for any
  // in-range temperature plus/minus a single step.
  localparam int SW = DATA_W + 1;
  localparam int WW = $clog2(WARMUP_STEPS + 1);

  localparam logic signed [SW-1:0] T_MIN_S  = SW'(T_MIN);
  localparam logic signed [SW-1:0] T_MAX_S  = SW'(T_MAX);
  localparam logic signed [SW-1:0] HEAT_S   = SW'(HEAT_RATE);
  localparam logic signed [SW-1:0] ONE_S    = SW'(1);
  localparam logic [DATA_W-1:0]    T_MIN_U  = DATA_W'(T_MIN);
  localparam logic [DATA_W-1:0]    T_MAX_U  = DATA_W'(T_MAX);
  localparam logic [DATA_W-1:0]    RESET_U  = DATA_W'(RESET_TEMP);
  localparam logic [WW-1:0]        WARM_END = WW'(WARMUP_STEPS);

  function automatic logic [DATA_W-1:0] sat(input logic signed [SW-1:0] v);
    if (v < T_MIN_S) begin
      sat = T_MIN_U;
    end else if (v > T_MAX_S) begin
      sat = T_MAX_U;
    end else begin
      sat = v[DATA_W-1:0];
    end
  endfunction

  // Cooling removes crs/2 degrees per step, but never less than one.
  function automatic logic signed [SW-1:0] cool_step(input logic [DATA_W-1:0] speed);
    logic [DATA_W-1:0] half;
    half = speed >> 1;
    if (half == '0) begin
      cool_step = ONE_S;
    end else begin
      cool_step = $signed({1'b0, half});
    end
  endfunction

  plant_state_t          state_q;
  plant_state_t          st_nxt;
  logic [WW-1:0]         warm_q;
  logic [WW-1:0]         warm_nxt;
  logic [WW-1:0]         warm_inc;
  logic [DATA_W-1:0]     t_nxt;
  logic [DATA_W-1:0]     amb_c;
  logic signed [SW-1:0]  t_s;
  logic                  tick;

  step_prescaler #(
    .STEP_CYCLES (STEP_CYCLES)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (load),
    .tick  (tick)
  );

  // Step evaluation: next state, warm-up count and temperature
  always_comb begin
    t_s      = $signed({1'b0, T});
    amb_c    = sat($signed({1'b0, ambient}));
    st_nxt   = state_q;
    warm_nxt = warm_q;
    warm_inc = warm_q + WW'(1);
    t_nxt    = T;

    if (heater && cooler) begin
      st_nxt   = PS_FAULT;
      warm_nxt = '0;
    end else if (state_q == PS_FAULT) begin
      // Leaving FAULT costs one step with T held.
      st_nxt   = PS_AMBIENT;
      warm_nxt = '0;
    end else if (heater) begin
      if (state_q == PS_HEATING) begin
        t_nxt = sat(t_s + HEAT_S);
      end else begin
        warm_nxt = warm_inc;
        st_nxt   = (warm_inc == WARM_END) ? PS_HEATING : PS_WARMUP;
      end
    end else if (cooler) begin
      st_nxt   = PS_COOLING;
      warm_nxt = '0;
      t_nxt    = sat(t_s - cool_step(crs));
    end else begin
      st_nxt   = PS_AMBIENT;
      warm_nxt = '0;
      if (T < amb_c) begin
        t_nxt = sat(t_s + ONE_S);
      end else if (T > amb_c) begin
        t_nxt = sat(t_s - ONE_S);
      end
    end
  end

  // Step commit: state and outputs registered together
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      T       <= RESET_U;
      t_valid <= 1'b0;
      fault   <= 1'b0;
      state_q <= PS_AMBIENT;
      warm_q  <= '0;
    end else if (load) begin
      T       <= sat($signed({1'b0, load_value}));
      t_valid <= 1'b1;
      fault   <= 1'b0;
      state_q <= PS_AMBIENT;
      warm_q  <= '0;
    end else if (tick) begin
      T       <= t_nxt;
      t_valid <= 1'b1;
      fault   <= (st_nxt == PS_FAULT);
      state_q <= st_nxt;
      warm_q  <= warm_nxt;
    end else begin
      t_valid <= 1'b0;
    end
  end

endmodule
